// File: rtl/lightgun_arb.sv
// Two-port light-gun hit arbiter: beam position counters, per-port first-edge
// hit capture, a presentation register with one pending slot, and crosshair overlay.
module lightgun_arb (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE_PIX,
  input  logic       HDE,
  input  logic       VDE,
  input  logic [1:0] EN,
  input  logic [1:0] SENSOR,
  input  logic [1:0] CROSS,
  input  logic       LATCH_ACK,
  output logic       LATCH_REQ,
  output logic       LATCH_PORT,
  output logic [9:0] HIT_H,
  output logic [8:0] HIT_V,
  output logic [1:0] MISS,
  output logic       OVF,
  output logic       CROSS_DRAW,
  output logic       CROSS_SEL
);

  typedef enum logic [1:0] {IDLE, PRESENT, REFILL} state_t;

  state_t     state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       hde_q, hde_d, vde_q, vde_d;
  logic [1:0] sensor_prev_q, sensor_prev_d;
  logic [1:0] hit_seen_q, hit_seen_d;
  logic [1:0] miss_q, miss_d;
  logic       ovf_q, ovf_d;
  logic       pres_port_q, pres_port_d;
  logic [9:0] pres_h_q, pres_h_d;
  logic [8:0] pres_line_q, pres_line_d;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_port_q, pend_port_d;
  logic [9:0] pend_h_q, pend_h_d;
  logic [8:0] pend_line_q, pend_line_d;
  logic       cross_draw_q, cross_draw_d;
  logic       cross_sel_q, cross_sel_d;

  logic       frame_start, frame_end;
  logic [1:0] seen_base, hit;
  logic       pres_occ, refill;

  assign frame_start = CE_PIX & VDE & ~vde_q;
  assign frame_end   = CE_PIX & ~VDE & vde_q;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    hde_d  = hde_q;
    vde_d  = vde_q;
    if (CE_PIX) begin
      hde_d = HDE;
      vde_d = VDE;
      if (!HDE)         hcnt_d = '0;
      else if (~&hcnt_q) hcnt_d = hcnt_q + 10'd1;
      if (!VDE)                              vcnt_d = '0;
      else if (hde_q && !HDE && ~&vcnt_q)    vcnt_d = vcnt_q + 9'd1;
    end
  end

  // Dropping EN re-arms the port, so a re-enabled gun may capture again this frame.
  always_comb begin
    sensor_prev_d = SENSOR;
    seen_base     = frame_start ? '0 : hit_seen_q;
    hit           = SENSOR & ~sensor_prev_q & EN & ~seen_base;
    hit_seen_d    = (seen_base | hit) & EN;
    miss_d        = frame_end ? (EN & ~(hit_seen_q | hit)) : miss_q;
    cross_draw_d  = |(CROSS & EN);
    cross_sel_d   = ~(CROSS[0] & EN[0]);
  end

  // Queue update in order: dequeue on ack, frame-start flush, then enqueue port 0 before port 1.
  always_comb begin
    pres_port_d  = pres_port_q;
    pres_h_d     = pres_h_q;
    pres_line_d  = pres_line_q;
    pend_valid_d = pend_valid_q;
    pend_port_d  = pend_port_q;
    pend_h_d     = pend_h_q;
    pend_line_d  = pend_line_q;
    ovf_d        = ovf_q;
    pres_occ     = (state_q != IDLE);
    refill       = 1'b0;

    if (state_q == PRESENT && LATCH_ACK) begin
      if (pend_valid_q) begin
        pres_port_d  = pend_port_q;
        pres_h_d     = pend_h_q;
        pres_line_d  = pend_line_q;
        pend_valid_d = 1'b0;
        refill       = 1'b1;
      end else begin
        pres_occ = 1'b0;
      end
    end

    if (frame_start) begin
      if (pres_occ || pend_valid_d) ovf_d = 1'b1;
      pres_occ     = 1'b0;
      pend_valid_d = 1'b0;
      refill       = 1'b0;
    end

    for (int unsigned i = 0; i < 2; i++) begin
      if (hit[i]) begin
        if (!pres_occ) begin
          pres_occ    = 1'b1;
          pres_port_d = i[0];
          pres_h_d    = hcnt_q;
          pres_line_d = vcnt_q;
        end else if (!pend_valid_d) begin
          pend_valid_d = 1'b1;
          pend_port_d  = i[0];
          pend_h_d     = hcnt_q;
          pend_line_d  = vcnt_q;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    if (!pres_occ)   state_d = IDLE;
    else if (refill) state_d = REFILL;
    else             state_d = PRESENT;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hde_q         <= 1'b0;
      vde_q         <= 1'b0;
      sensor_prev_q <= '1;
      hit_seen_q    <= '0;
      miss_q        <= '0;
      ovf_q         <= 1'b0;
      pres_port_q   <= 1'b0;
      pres_h_q      <= '0;
      pres_line_q   <= '0;
      pend_valid_q  <= 1'b0;
      pend_port_q   <= 1'b0;
      pend_h_q      <= '0;
      pend_line_q   <= '0;
      cross_draw_q  <= 1'b0;
      cross_sel_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hde_q         <= hde_d;
      vde_q         <= vde_d;
      sensor_prev_q <= sensor_prev_d;
      hit_seen_q    <= hit_seen_d;
      miss_q        <= miss_d;
      ovf_q         <= ovf_d;
      pres_port_q   <= pres_port_d;
      pres_h_q      <= pres_h_d;
      pres_line_q   <= pres_line_d;
      pend_valid_q  <= pend_valid_d;
      pend_port_q   <= pend_port_d;
      pend_h_q      <= pend_h_d;
      pend_line_q   <= pend_line_d;
      cross_draw_q  <= cross_draw_d;
      cross_sel_q   <= cross_sel_d;
    end
  end

  assign LATCH_REQ  = (state_q == PRESENT);
  assign LATCH_PORT = pres_port_q;
  assign HIT_H      = pres_h_q;
  assign HIT_V      = pres_line_q;
  assign MISS       = miss_q;
  assign OVF        = ovf_q;
  assign CROSS_DRAW = cross_draw_q;
  assign CROSS_SEL  = cross_sel_q;

endmodule

// File: tb/tb_lightgun_arb.sv
// Directed bench for lightgun_arb with hand-computed expectations.
module tb_lightgun_arb;

  logic       CLK = 1'b0;
  logic       RESET_N, CE_PIX, HDE, VDE, LATCH_ACK;
  logic [1:0] EN, SENSOR, CROSS;
  logic       LATCH_REQ, LATCH_PORT, OVF, CROSS_DRAW, CROSS_SEL;
  logic [9:0] HIT_H;
  logic [8:0] HIT_V;
  logic [1:0] MISS;
  int         checks = 0;
  int         fails  = 0;

  lightgun_arb dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HDE(HDE), .VDE(VDE),
    .EN(EN), .SENSOR(SENSOR), .CROSS(CROSS), .LATCH_ACK(LATCH_ACK),
    .LATCH_REQ(LATCH_REQ), .LATCH_PORT(LATCH_PORT), .HIT_H(HIT_H), .HIT_V(HIT_V),
    .MISS(MISS), .OVF(OVF), .CROSS_DRAW(CROSS_DRAW), .CROSS_SEL(CROSS_SEL)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      HDE = 1'b1; tick();
      HDE = 1'b0; tick();
    end
  endtask

  task automatic frame_begin();
    HDE = 1'b0; VDE = 1'b0; tick(2);
    VDE = 1'b1; tick();
  endtask

  task automatic chk_rec(input string nm, input logic req, input logic port,
                         input logic [9:0] h, input logic [8:0] v);
    checks++;
    if ({LATCH_REQ, LATCH_PORT, HIT_H, HIT_V} !== {req, port, h, v}) begin
      fails++;
      $display("FAIL %s: got req=%0d port=%0d h=%0d v=%0d, want req=%0d port=%0d h=%0d v=%0d",
               nm, LATCH_REQ, LATCH_PORT, HIT_H, HIT_V, req, port, h, v);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; CE_PIX = 1'b1; HDE = 1'b0; VDE = 1'b0;
    EN = '0; SENSOR = '0; CROSS = '0; LATCH_ACK = 1'b0;
    #1;
    chk_rec("reset_rec", 1'b0, 1'b0, 10'd0, 9'd0);
    checks++;
    if ({MISS, OVF, CROSS_DRAW, CROSS_SEL} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {MISS, OVF, CROSS_DRAW, CROSS_SEL});
    end
    tick(2);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_single_hit();
    EN = 2'b01;
    frame_begin();
    lines(50);
    HDE = 1'b1; tick(100);
    SENSOR = 2'b01; tick();
    chk_rec("single_first", 1'b1, 1'b0, 10'd100, 9'd50);
    tick(5);
    chk_rec("single_hold", 1'b1, 1'b0, 10'd100, 9'd50);
    LATCH_ACK = 1'b1; tick(); LATCH_ACK = 1'b0;
    checks++;
    if (LATCH_REQ !== 1'b0) begin fails++; $display("FAIL single_ack: got req=%0d want 0", LATCH_REQ); end
    SENSOR = 2'b00; tick();
    SENSOR = 2'b01; tick(2);
    checks++;
    if (LATCH_REQ !== 1'b0) begin fails++; $display("FAIL single_second_edge: got req=%0d want 0", LATCH_REQ); end
    SENSOR = 2'b00;
  endtask

  task automatic test_simultaneous();
    EN = 2'b11;
    frame_begin();
    lines(80);
    HDE = 1'b1; tick(200);
    SENSOR = 2'b11; tick();
    chk_rec("simul_p0", 1'b1, 1'b0, 10'd200, 9'd80);
    LATCH_ACK = 1'b1; tick(); LATCH_ACK = 1'b0;
    checks++;
    if (LATCH_REQ !== 1'b0) begin fails++; $display("FAIL simul_refill: got req=%0d want 0", LATCH_REQ); end
    tick();
    chk_rec("simul_p1", 1'b1, 1'b1, 10'd200, 9'd80);
    checks++;
    if (OVF !== 1'b0) begin fails++; $display("FAIL simul_ovf: got %0d want 0", OVF); end
    LATCH_ACK = 1'b1; tick(); LATCH_ACK = 1'b0;
    SENSOR = 2'b00;
  endtask

  task automatic test_ack_with_hit();
    EN = 2'b11;
    frame_begin();
    lines(3);
    HDE = 1'b1; tick(10);
    SENSOR = 2'b01; tick();
    chk_rec("ackhit_first", 1'b1, 1'b0, 10'd10, 9'd3);
    LATCH_ACK = 1'b1; SENSOR = 2'b11; tick(); LATCH_ACK = 1'b0;
    chk_rec("ackhit_direct", 1'b1, 1'b1, 10'd11, 9'd3);
    tick();
    chk_rec("ackhit_hold", 1'b1, 1'b1, 10'd11, 9'd3);
    LATCH_ACK = 1'b1; tick(); LATCH_ACK = 1'b0;
    checks++;
    if (LATCH_REQ !== 1'b0) begin fails++; $display("FAIL ackhit_idle: got req=%0d want 0", LATCH_REQ); end
    SENSOR = 2'b00;
  endtask

  task automatic test_miss();
    EN = 2'b10;
    frame_begin();
    lines(2);
    VDE = 1'b0; tick();
    checks++;
    if (MISS !== 2'b10) begin fails++; $display("FAIL miss_set: got %b want 10", MISS); end
    VDE = 1'b1; tick();
    lines(1);
    HDE = 1'b1; tick(5);
    SENSOR = 2'b10; tick();
    chk_rec("miss_hit", 1'b1, 1'b1, 10'd5, 9'd1);
    LATCH_ACK = 1'b1; tick(); LATCH_ACK = 1'b0;
    HDE = 1'b0; VDE = 1'b0; tick();
    checks++;
    if (MISS !== 2'b00) begin fails++; $display("FAIL miss_clear: got %b want 00", MISS); end
    SENSOR = 2'b00;
  endtask

  task automatic test_cross();
    EN = 2'b01; CROSS = 2'b01; tick();
    checks++;
    if ({CROSS_DRAW, CROSS_SEL} !== 2'b10) begin fails++; $display("FAIL cross_p0: got %b want 10", {CROSS_DRAW, CROSS_SEL}); end
    EN = 2'b11; CROSS = 2'b10; tick();
    checks++;
    if ({CROSS_DRAW, CROSS_SEL} !== 2'b11) begin fails++; $display("FAIL cross_p1: got %b want 11", {CROSS_DRAW, CROSS_SEL}); end
    EN = 2'b01; tick();
    checks++;
    if (CROSS_DRAW !== 1'b0) begin fails++; $display("FAIL cross_masked: got %0d want 0", CROSS_DRAW); end
    CROSS = 2'b00;
  endtask

  task automatic test_overflow();
    checks++;
    if (OVF !== 1'b0) begin fails++; $display("FAIL ovf_pre: got %0d want 0", OVF); end
    EN = 2'b11;
    frame_begin();
    lines(1);
    HDE = 1'b1; tick(20);
    SENSOR = 2'b11; tick();
    SENSOR = 2'b00; EN = 2'b00; tick();
    EN = 2'b01; tick();
    SENSOR = 2'b01; tick();
    chk_rec("ovf_pres_kept", 1'b1, 1'b0, 10'd20, 9'd1);
    checks++;
    if (OVF !== 1'b1) begin fails++; $display("FAIL ovf_set: got %0d want 1", OVF); end
    LATCH_ACK = 1'b1; tick(); LATCH_ACK = 1'b0;
    tick();
    chk_rec("ovf_pending", 1'b1, 1'b1, 10'd20, 9'd1);
    LATCH_ACK = 1'b1; tick(); LATCH_ACK = 1'b0;
    SENSOR = 2'b00;
  endtask

  task automatic test_reset_mid();
    EN = 2'b01;
    frame_begin();
    lines(1);
    HDE = 1'b1; tick(7);
    SENSOR = 2'b01; tick();
    chk_rec("rstmid_pre", 1'b1, 1'b0, 10'd7, 9'd1);
    RESET_N = 1'b0; #1;
    chk_rec("rstmid_async", 1'b0, 1'b0, 10'd0, 9'd0);
    checks++;
    if ({MISS, OVF, CROSS_DRAW, CROSS_SEL} !== 5'b0) begin
      fails++; $display("FAIL rstmid_flags: got %b want 00000", {MISS, OVF, CROSS_DRAW, CROSS_SEL});
    end
    tick();
    RESET_N = 1'b1;
    tick(5);
    checks++;
    if (LATCH_REQ !== 1'b0) begin fails++; $display("FAIL rstmid_nohit: got req=%0d want 0", LATCH_REQ); end
    SENSOR = 2'b00;
  endtask

  task automatic test_frame_drop();
    EN = 2'b01;
    frame_begin();
    lines(2);
    HDE = 1'b1; tick(4);
    SENSOR = 2'b01; tick();
    chk_rec("drop_pre", 1'b1, 1'b0, 10'd4, 9'd2);
    frame_begin();
    checks++;
    if ({LATCH_REQ, OVF} !== 2'b01) begin fails++; $display("FAIL drop_flush: got req,ovf=%b want 01", {LATCH_REQ, OVF}); end
    SENSOR = 2'b00;
  endtask

  task automatic test_saturation();
    EN = 2'b01;
    frame_begin();
    lines(515);
    HDE = 1'b1; tick(1100);
    SENSOR = 2'b01; tick();
    chk_rec("sat_max", 1'b1, 1'b0, 10'd1023, 9'd511);
    LATCH_ACK = 1'b1; tick(); LATCH_ACK = 1'b0;
    SENSOR = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_simultaneous();
    test_ack_with_hit();
    test_miss();
    test_cross();
    test_overflow();
    test_reset_mid();
    test_frame_drop();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
